// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  localparam int unsigned GLITCH_CNT_W = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw input; emits edge strobes and a saturating
// count of rejected (too short) transitions.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_raw,
  input  logic                    glitch_clr,
  output logic                    a_clean,
  output logic                    rise,
  output logic                    fall,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit              SINGLE   = (DEBOUNCE_CYCLES == 1);

  logic             a_sync;
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             glitch_c;
  logic             clean_next_c;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (a_raw),
    .q  (a_sync)
  );

  // Next-state logic: count consecutive opposite samples, abort on a glitch.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    glitch_c   = 1'b0;
    case (state)
      S_LOW: begin
        if (a_sync) begin
          if (SINGLE) begin
            next_state = S_HIGH;
            cnt_next   = '0;
          end else begin
            next_state = S_RISE;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      S_RISE: begin
        if (a_sync) begin
          if (cnt == CNT_LAST) begin
            next_state = S_HIGH;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end else begin
          next_state = S_LOW;
          cnt_next   = '0;
          glitch_c   = 1'b1;
        end
      end
      S_HIGH: begin
        if (!a_sync) begin
          if (SINGLE) begin
            next_state = S_LOW;
            cnt_next   = '0;
          end else begin
            next_state = S_FALL;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      S_FALL: begin
        if (!a_sync) begin
          if (cnt == CNT_LAST) begin
            next_state = S_LOW;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end else begin
          next_state = S_HIGH;
          cnt_next   = '0;
          glitch_c   = 1'b1;
        end
      end
      default: begin
        next_state = S_LOW;
        cnt_next   = '0;
      end
    endcase
    clean_next_c = (next_state == S_HIGH) || (next_state == S_FALL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOW;
      cnt        <= '0;
      a_clean    <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      a_clean <= clean_next_c;
      rise    <= clean_next_c & ~a_clean;
      fall    <= ~clean_next_c & a_clean;
      // Clear takes priority over a coincident glitch; the count saturates.
      if (glitch_clr) begin
        glitch_cnt <= '0;
      end else if (glitch_c && (glitch_cnt != '1)) begin
        glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized and directed checks of input_debouncer against a run-length model.
module tb_input_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic a_raw;
  logic glitch_clr;

  logic       a_clean0, rise0, fall0;
  logic [7:0] gcnt0;
  logic       a_clean1, rise1, fall1;
  logic [7:0] gcnt1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model parameters per instance: [0] = 2 stages / 4 cycles, [1] = 3 stages / 1 cycle.
  int m_sync [2] = '{2, 3};
  int m_deb  [2] = '{4, 1};

  bit m_sh    [2][4];
  bit m_clean [2];
  bit m_rise  [2];
  bit m_fall  [2];
  int m_run   [2];
  int m_gcnt  [2];

  always #5 clk = ~clk;

  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .a_raw(a_raw), .glitch_clr(glitch_clr),
    .a_clean(a_clean0), .rise(rise0), .fall(fall0), .glitch_cnt(gcnt0)
  );

  input_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .a_raw(a_raw), .glitch_clr(glitch_clr),
    .a_clean(a_clean1), .rise(rise1), .fall(fall1), .glitch_cnt(gcnt1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // A level change needs DEBOUNCE_CYCLES consecutive opposite synchronized samples;
  // an opposite run broken before that is one glitch.
  task automatic model_edge(input int k, input bit r, input bit raw, input bit clr);
    bit s;
    bit prev;
    bit glitch;
    if (r) begin
      for (int i = 0; i < 4; i++) m_sh[k][i] = 1'b0;
      m_clean[k] = 1'b0; m_rise[k] = 1'b0; m_fall[k] = 1'b0;
      m_run[k] = 0; m_gcnt[k] = 0;
      return;
    end
    s = m_sh[k][m_sync[k]-1];
    for (int i = 3; i > 0; i--) m_sh[k][i] = m_sh[k][i-1];
    m_sh[k][0] = raw;
    prev = m_clean[k];
    glitch = 1'b0;
    if (s != m_clean[k]) begin
      m_run[k]++;
      if (m_run[k] == m_deb[k]) begin
        m_clean[k] = ~m_clean[k];
        m_run[k] = 0;
      end
    end else begin
      glitch = (m_run[k] > 0);
      m_run[k] = 0;
    end
    m_rise[k] = m_clean[k] & ~prev;
    m_fall[k] = ~m_clean[k] & prev;
    if (clr) m_gcnt[k] = 0;
    else if (glitch && m_gcnt[k] < 255) m_gcnt[k]++;
  endtask

  task automatic step(input bit raw, input bit clr, input bit r);
    a_raw = raw; glitch_clr = clr; rst = r;
    @(posedge clk);
    model_edge(0, r, raw, clr);
    model_edge(1, r, raw, clr);
    #1;
    check("clean0", 16'(a_clean0), 16'(m_clean[0]));
    check("rise0",  16'(rise0),    16'(m_rise[0]));
    check("fall0",  16'(fall0),    16'(m_fall[0]));
    check("gcnt0",  16'(gcnt0),    16'(m_gcnt[0]));
    check("clean1", 16'(a_clean1), 16'(m_clean[1]));
    check("rise1",  16'(rise1),    16'(m_rise[1]));
    check("fall1",  16'(fall1),    16'(m_fall[1]));
    check("gcnt1",  16'(gcnt1),    16'(m_gcnt[1]));
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    a_raw = 1'b0; glitch_clr = 1'b0; rst = 1'b1;
    do_reset();
    check("reset_clean", 16'(a_clean0), 16'd0);
    check("reset_gcnt",  16'(gcnt0),    16'd0);

    // Held high after reset: clean rises after edge 6, strobe lasts one cycle.
    for (int e = 1; e <= 7; e++) begin
      step(1'b1, 1'b0, 1'b0);
      if (e == 5) check("lat_e5_clean", 16'(a_clean0), 16'd0);
      if (e == 6) begin
        check("lat_e6_clean", 16'(a_clean0), 16'd1);
        check("lat_e6_rise",  16'(rise0),    16'd1);
      end
      if (e == 7) check("lat_e7_rise", 16'(rise0), 16'd0);
    end

    // Held low: fall strobe after edge 6 from the change.
    for (int e = 1; e <= 7; e++) begin
      step(1'b0, 1'b0, 1'b0);
      if (e == 6) begin
        check("fall_e6_fall",  16'(fall0),    16'd1);
        check("fall_e6_clean", 16'(a_clean0), 16'd0);
      end
      if (e == 7) check("fall_e7_fall", 16'(fall0), 16'd0);
    end

    // Bounce 1,0,1,1,0 then steady 1: two glitches, then a clean rise.
    do_reset();
    begin
      bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) step(pat[i], 1'b0, 1'b0);
    end
    for (int e = 1; e <= 6; e++) begin
      step(1'b1, 1'b0, 1'b0);
      if (e == 5) check("bounce_e5_clean", 16'(a_clean0), 16'd0);
      if (e == 6) check("bounce_e6_rise",  16'(rise0),    16'd1);
    end
    check("bounce_gcnt", 16'(gcnt0), 16'd2);

    // Reset during the rise count aborts without strobe or glitch.
    do_reset();
    for (int e = 1; e <= 4; e++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("abort_clean", 16'(a_clean0), 16'd0);
    check("abort_rise",  16'(rise0),    16'd0);
    check("abort_gcnt",  16'(gcnt0),    16'd0);
    step(1'b0, 1'b0, 1'b0);
    check("abort_post_rise", 16'(rise0), 16'd0);
    check("abort_post_gcnt", 16'(gcnt0), 16'd0);

    // 300 single-sample glitches saturate the counter.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("sat_gcnt",  16'(gcnt0),    16'd255);
    check("sat_clean", 16'(a_clean0), 16'd0);
    check("n1_gcnt",   16'(gcnt1),    16'd0);
    // Clear coincident with a glitch event: clear wins.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("clr_coincident", 16'(gcnt0), 16'd0);
    step(1'b0, 1'b0, 1'b0);
    check("clr_hold", 16'(gcnt0), 16'd0);

    // Randomized runs with occasional clears and resets.
    do_reset();
    begin
      bit lvl = 1'b0;
      for (int burst = 0; burst < 700; burst++) begin
        int len = $urandom_range(1, 6);
        lvl = ~lvl;
        for (int i = 0; i < len; i++) begin
          step(lvl, ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on a_raw; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive equal synchronized samples needed to change the clean level; legal range 1..65535.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port a_raw  input  1: asynchronous, possibly bouncing input.
REQ-006 Port glitch_clr  input  1: synchronous clear of glitch_cnt.
REQ-007 Port a_clean  output  1: debounced level; feeds the downstream edge/pulse detectors' input a.
REQ-008 Port rise  output  1: one-cycle strobe when a_clean goes 0->1.
REQ-009 Port fall  output  1: one-cycle strobe when a_clean goes 1->0.
REQ-010 Port glitch_cnt  output  8: saturating count of rejected transitions.

Function
REQ-011 The block SHALL pass a_raw through a SYNC_STAGES-deep flop chain; the last flop output is a_sync; all other logic uses only a_sync.
REQ-012 The FSM SHALL have four states: S_LOW, S_RISE, S_HIGH, S_FALL; a_clean = 1 exactly in S_HIGH and S_FALL.
REQ-013 S_LOW, a_sync=0: stay. S_LOW, a_sync=1: go to S_HIGH if DEBOUNCE_CYCLES=1, else go to S_RISE with cnt=1.
REQ-014 S_RISE, a_sync=1: go to S_HIGH if cnt+1 = DEBOUNCE_CYCLES, else cnt<=cnt+1. S_RISE, a_sync=0: go to S_LOW, cnt<=0, glitch event.
REQ-015 S_HIGH and S_FALL SHALL mirror REQ-013/014 with polarity inverted (S_FALL->S_LOW on completion; S_FALL->S_HIGH on glitch).
REQ-016 a_clean, rise and fall SHALL be registered; rise/fall are high for exactly the one cycle after the edge where a_clean changes, and never both high.
REQ-017 Latency: with a_raw stable before edge e0 and held, a_clean SHALL change after edge e0+SYNC_STAGES+DEBOUNCE_CYCLES-1 (SYNC_STAGES+DEBOUNCE_CYCLES edges, counting e0).
REQ-018 A synchronized pulse shorter than DEBOUNCE_CYCLES samples SHALL NOT change a_clean and SHALL produce exactly one glitch event.
REQ-019 cnt width SHALL be $clog2(DEBOUNCE_CYCLES+1) and SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-020 glitch_cnt SHALL increment by 1 per glitch event and saturate at 255 (no wrap).
REQ-021 glitch_clr SHALL set glitch_cnt to 0 on the next edge; a simultaneous glitch event is dropped (clear wins).
REQ-022 glitch_clr SHALL NOT affect the FSM, cnt or a_clean.

Reset
REQ-023 While rst=1 at an edge, all sync flops SHALL be 0, state S_LOW, cnt 0, a_clean 0, rise 0, fall 0, glitch_cnt 0.
REQ-024 Reset asserted mid-debounce SHALL abort the count with no rise/fall strobe and no glitch event.
REQ-025 After rst deasserts with a_raw held 1, a_clean SHALL rise per REQ-017, counting from the first edge with rst=0.

Structure
REQ-026 Shared package debounce_pkg SHALL hold the FSM state typedef (S_LOW, S_RISE, S_HIGH, S_FALL) and the constant GLITCH_CNT_W=8.
REQ-027 The synchronizer SHALL be a separate sub-module sync_chain (parameter STAGES; ports clk, rst, d, q), instantiated once.

Verification
REQ-028 Reset, a_raw=1 from first edge after rst=0, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 -> a_clean=1 and rise=1 after edge 6; rise=0 after edge 7.
REQ-029 Bounce: a_raw sampled 1,0,1,1,0 then steady 1 (N=4) -> two glitch events (glitch_cnt=2); a_clean rises 5 edges after the final 0->1.
REQ-030 Fall: from a_clean=1, a_raw=0 held -> fall=1 for one cycle after edge 6 from the change; a_clean=0.
REQ-031 Saturation: 300 one-cycle glitches -> glitch_cnt=255; glitch_clr with a coincident glitch -> glitch_cnt=0.
REQ-032 DEBOUNCE_CYCLES=1: one-sample a_raw pulse -> a_clean follows a_sync with a 1-cycle lag; glitch_cnt stays 0.
REQ-033 rst=1 asserted during S_RISE at cnt=2 -> no rise strobe, glitch_cnt unchanged, state S_LOW.
